button_conditioner: RTL and testbench

- Upstream input stage for the reaction-timer top level.
- Takes raw board push-buttons and switches (mode, enter, stop, ...) and synchronizes each to clk_100MHz.
- Debounces each input with a per-channel stability counter.
- Emits a clean level plus single-cycle rise and fall strobes per channel; the timer FSM and display-mode mux consume these instead of raw pins.

---
 rtl/button_conditioner.sv | 149 ++++++++++++++
 tb/tb_button_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// button_conditioner: input conditioning for raw push-buttons and switches.
// Each channel is brought into the clk_100MHz domain through two flops.
// A per-channel stability counter then debounces it, and the block produces
// a clean level plus registered one-cycle rise/fall strobes.
//
// Ports:
//   clk_100MHz  in   system clock, the only clock
//   reset       in   synchronous, active-high reset
//   btn_raw     in   [NUM_BTNS]  asynchronous raw inputs
//   btn_level   out  [NUM_BTNS]  debounced level
//   btn_rise    out  [NUM_BTNS]  one-cycle strobe on an accepted 0->1
//   btn_fall    out  [NUM_BTNS]  one-cycle strobe on an accepted 1->0
//   btn_long    out  [NUM_BTNS]  one-cycle long-press strobe
//
// Optional feature macro: LONG_PRESS_EN.
//   When the macro is defined, each channel has a hold counter. btn_long
//   pulses once HOLD_CYCLES cycles after btn_rise, provided the level stays
//   high for that whole time.
//   When the macro is undefined, btn_long is tied to 0 and no hold logic is
//   built.
//
// Latency: if s1 first captures a new stable value on edge k, btn_level and
// its strobe update on edge k+1+DEBOUNCE_CYCLES.
// Backpressure: none. The outputs are free-running.

module button_conditioner #(
  parameter int NUM_BTNS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic                clk_100MHz,
  input  logic                reset,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_rise,
  output logic [NUM_BTNS-1:0] btn_fall,
  output logic [NUM_BTNS-1:0] btn_long
);

  // The counter only has to reach DEBOUNCE_CYCLES-1. The terminal compare
  // therefore fires before the counter could wrap.
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Parameter legality checks, evaluated at elaboration.
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_conditioner: HOLD_CYCLES must be >= 1");
  end

  // --------------------------------------------------------------------
  // Two-flop synchronizer. No logic sits between s1 and s2, and only s2
  // is allowed to feed the debounce logic.
  // --------------------------------------------------------------------
  logic [NUM_BTNS-1:0] s1;
  logic [NUM_BTNS-1:0] s2;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  // --------------------------------------------------------------------
  // Per-channel debounce and optional long-press detection
  // --------------------------------------------------------------------
  for (genvar ch = 0; ch < NUM_BTNS; ch++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;

    // The counter measures how long s2 has disagreed with the accepted
    // level without a break. A single agreeing cycle throws away the
    // partial count, so bounces shorter than DEBOUNCE_CYCLES never reach
    // the outputs.
    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        cnt     <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (s2[ch] == level_q) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          // Accept the new level. Only one of rise/fall can fire here.
          level_q <= s2[ch];
          cnt     <= '0;
          rise_q  <= s2[ch];
          fall_q  <= ~s2[ch];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign btn_level[ch] = level_q;
    assign btn_rise[ch]  = rise_q;
    assign btn_fall[ch]  = fall_q;

`ifdef LONG_PRESS_EN
    localparam int               HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt;
    logic              fired;
    logic              long_q;

    // The hold counter runs while the accepted level is high and saturates
    // at HOLD_MAX. The strobe fires on the edge where the counter reaches
    // HOLD_MAX. Because level_q is already high in the cycle after the
    // rise edge, that is exactly HOLD_CYCLES cycles after btn_rise.
    // The fired flag makes the strobe one-shot per press.
    always_ff @(posedge clk_100MHz) begin
      if (reset) begin
        hold_cnt <= '0;
        fired    <= 1'b0;
        long_q   <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (!level_q) begin
          hold_cnt <= '0;
          fired    <= 1'b0;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
          if ((hold_cnt == HOLD_MAX - 1'b1) && !fired) begin
            long_q <= 1'b1;
            fired  <= 1'b1;
          end
        end
      end
    end

    assign btn_long[ch] = long_q;
`else
    assign btn_long[ch] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner, with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=10.
// Directed presses, bounces and a mid-press reset come first, followed by
// random run-length stimulus.
// The reference model works on the history of sampled raw inputs. A channel
// flips when the DEBOUNCE_CYCLES most recent synchronized samples all differ
// from its level.

module tb_button_conditioner;

  localparam int N    = 3;
  localparam int D    = 4;
  localparam int H    = 10;
  localparam int MAXC = 4000;

  logic         clk_100MHz = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_rise;
  logic [N-1:0] btn_fall;
  logic [N-1:0] btn_long;

  always #5 clk_100MHz = ~clk_100MHz;

  button_conditioner #(
    .NUM_BTNS       (N),
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_long  (btn_long)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [N-1:0] hist [0:MAXC];   // btn_raw as sampled at each clock edge
  logic [N-1:0] m_level;
  logic [N-1:0] m_rise;
  logic [N-1:0] m_fall;
  logic [N-1:0] m_long;
  int           rise_edge [N];
  int           n = 0;           // index of the current clock edge

  task automatic model_step(input logic r_rst, input logic [N-1:0] r_raw);
    m_rise = '0;
    m_fall = '0;
    m_long = '0;
    if (r_rst) begin
      // Reset zeroes both synchronizer stages. These two history slots
      // therefore read as 0 from now on.
      hist[n] = '0;
      if (n > 0) hist[n-1] = '0;
      m_level = '0;
      for (int c = 0; c < N; c++) rise_edge[c] = -1;
    end else begin
      hist[n] = r_raw;
      for (int c = 0; c < N; c++) begin
        logic pre;
        logic all_new;
        pre = m_level[c];
`ifdef LONG_PRESS_EN
        if (pre && rise_edge[c] >= 0 && (n - rise_edge[c]) == H) m_long[c] = 1'b1;
`endif
        // The debounce logic at edge n sees the sample taken at edge n-2.
        // It accepts a new level only after D consecutive such samples
        // all differ from the current level.
        all_new = (n - 1 - D) >= 0;
        for (int j = 0; j < D; j++)
          if (all_new && hist[n-2-j][c] == pre) all_new = 1'b0;
        if (all_new) begin
          m_level[c] = ~pre;
          m_rise[c]  = ~pre;
          m_fall[c]  = pre;
          if (!pre) rise_edge[c] = n;
        end
      end
    end
    n++;
  endtask

  int rise_cnt [N];
  int long_cnt [N];

  task automatic drive(input logic r, input logic [N-1:0] v);
    @(negedge clk_100MHz);
    reset   = r;
    btn_raw = v;
    @(posedge clk_100MHz);
    model_step(r, v);
    #1;
    check("level", btn_level, m_level);
    check("rise",  btn_rise,  m_rise);
    check("fall",  btn_fall,  m_fall);
    check("long",  btn_long,  m_long);
    for (int c = 0; c < N; c++) begin
      if (btn_rise[c]) rise_cnt[c]++;
      if (btn_long[c]) long_cnt[c]++;
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < N; c++) begin
      rise_cnt[c] = 0;
      long_cnt[c] = 0;
    end
  endtask

  logic [N-1:0] cur;
  int           rem [N];

  initial begin
    for (int i = 0; i <= MAXC; i++) hist[i] = '0;
    m_level = '0;
    for (int c = 0; c < N; c++) rise_edge[c] = -1;
    clear_counts();
    reset   = 1'b1;
    btn_raw = '0;

    repeat (3) drive(1'b1, 3'b000);

    // Clean press on channel 1: exactly one rise, and channel 1 only.
    clear_counts();
    repeat (12) drive(1'b0, 3'b010);
    check("ch1_rises", rise_cnt[1], 1);
    check("ch0_rises", rise_cnt[0], 0);
    repeat (12) drive(1'b0, 3'b000);

    // Channel 2 bounces in runs of 3: nothing is ever accepted.
    clear_counts();
    for (int r = 0; r < 2; r++) begin
      repeat (3) drive(1'b0, 3'b100);
      drive(1'b0, 3'b000);
    end
    repeat (8) drive(1'b0, 3'b000);
    check("bounce_rises", rise_cnt[2], 0);

    // Channels 0 and 2 pressed together, then released together.
    repeat (12) drive(1'b0, 3'b101);
    repeat (12) drive(1'b0, 3'b000);

    // Reset lands 5 cycles into a press: exactly one rise follows it.
    repeat (5) drive(1'b0, 3'b001);
    drive(1'b1, 3'b001);
    clear_counts();
    repeat (15) drive(1'b0, 3'b001);
    check("post_reset_rises", rise_cnt[0], 1);
    repeat (12) drive(1'b0, 3'b000);

    // Two separate long holds on channel 1.
    clear_counts();
    for (int r = 0; r < 2; r++) begin
      repeat (40) drive(1'b0, 3'b010);
      repeat (10) drive(1'b0, 3'b000);
    end
`ifdef LONG_PRESS_EN
    check("long_count", long_cnt[1], 2);
`else
    check("long_count", long_cnt[1], 0);
`endif

    // Random run-length stimulus. Short runs are bounces and long runs are
    // presses; a reset is injected now and then.
    cur = '0;
    for (int c = 0; c < N; c++) rem[c] = 0;
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          cur[c] = ~cur[c];
          rem[c] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, D - 1))
                                               : int'($urandom_range(D, 30));
        end
        rem[c]--;
      end
      drive(($urandom_range(0, 299) == 0), cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
